// File: rtl/wam_pkg.sv
// Shared types and defaults for the whack-a-mole hit tracker.
package wam_pkg;

   localparam int SCORE_W_DEF    = 6;
   localparam int NUM_LIGHTS_DEF = 9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_SCORED = 2'd2,
      ST_LOCKED = 2'd3
   } trk_state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a held key level; stays quiet until the level
// has been seen low once after reset, so a key held through reset is not a press.
module edge_detect (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;
   logic seen_low;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         sig_q    <= 1'b0;
         seen_low <= 1'b0;
      end else begin
         sig_q <= sig;
         if (!sig)
            seen_low <= 1'b1;
      end
   end

   assign rise = sig & ~sig_q & seen_low;

endmodule

// File: rtl/hit_tracker.sv
// Scores key presses against the lit position: points, misses and lives.
//   state     | meaning
//   ST_IDLE   | no light armed
//   ST_ARMED  | light lit, not yet hit
//   ST_SCORED | current light already hit
//   ST_LOCKED | out of lives, waiting for clear or reset
module hit_tracker
   import wam_pkg::*;
#(
   parameter int SCORE_W    = SCORE_W_DEF,
   parameter int NUM_LIGHTS = NUM_LIGHTS_DEF
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               clear_n,
   input  logic               enable,
   input  logic               use_lives,
   input  logic [1:0]         lives_init,
   input  logic               light_new,
   input  logic [3:0]         light_pos,
   input  logic               valid_key,
   input  logic [3:0]         key,
   output logic [SCORE_W-1:0] total_points,
   output logic [SCORE_W-1:0] misses,
   output logic [1:0]         lives_left,
   output logic               hit,
   output logic               out_of_lives
);

   localparam logic [SCORE_W-1:0] CNT_MAX = '1;
   localparam logic [4:0]         NUM_L   = 5'(NUM_LIGHTS);

   trk_state_t         state;
   logic               press;
   logic               key_ok;
   logic [1:0]         n_miss;
   logic [SCORE_W:0]   pts_sum;
   logic [SCORE_W:0]   mis_sum;
   logic [SCORE_W-1:0] pts_next;
   logic [SCORE_W-1:0] mis_next;
   logic [1:0]         lives_next;
   logic               lose_all;

   edge_detect u_key_edge (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .sig      (valid_key),
      .rise     (press)
   );

   // A light change while armed always costs the outgoing light, and the
   // press in that same cycle is judged against the incoming position.
   always_comb begin
      key_ok     = ({1'b0, key} < NUM_L) && (key == light_pos);
      n_miss     = {1'b0, light_new} + {1'b0, press & ~key_ok};
      pts_sum    = {1'b0, total_points} + {{SCORE_W{1'b0}}, press & key_ok};
      mis_sum    = {1'b0, misses} + {{(SCORE_W-1){1'b0}}, n_miss};
      pts_next   = pts_sum[SCORE_W] ? CNT_MAX : pts_sum[SCORE_W-1:0];
      mis_next   = mis_sum[SCORE_W] ? CNT_MAX : mis_sum[SCORE_W-1:0];
      lose_all   = use_lives && (n_miss != 2'd0) && (lives_left <= n_miss);
      lives_next = lives_left;
      if (use_lives)
         lives_next = lose_all ? 2'd0 : (lives_left - n_miss);
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         total_points <= '0;
         misses       <= '0;
         lives_left   <= 2'd3;
         hit          <= 1'b0;
         out_of_lives <= 1'b0;
      end else if (!clear_n) begin
         state        <= ST_IDLE;
         total_points <= '0;
         misses       <= '0;
         lives_left   <= lives_init;
         hit          <= 1'b0;
         out_of_lives <= 1'b0;
      end else begin
         hit <= 1'b0;
         if (!enable) begin
            // A locked game stays locked; only a clear brings it back.
            if (state != ST_LOCKED)
               state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (light_new)
                     state <= ST_ARMED;
               end
               ST_ARMED: begin
                  total_points <= pts_next;
                  misses       <= mis_next;
                  lives_left   <= lives_next;
                  if (press && key_ok) begin
                     hit   <= 1'b1;
                     state <= ST_SCORED;
                  end
                  if (lose_all) begin
                     out_of_lives <= 1'b1;
                     state        <= ST_LOCKED;
                  end
               end
               ST_SCORED: begin
                  if (light_new)
                     state <= ST_ARMED;
               end
               ST_LOCKED: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hit_tracker.sv
// Scoreboard bench for hit_tracker: each step queues its expected outputs,
// which are popped and compared once the clock edge has taken effect.
module tb_hit_tracker;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       clear_n;
   logic       enable;
   logic       use_lives;
   logic [1:0] lives_init;
   logic       light_new;
   logic [3:0] light_pos;
   logic       valid_key;
   logic [3:0] key;
   logic [5:0] total_points;
   logic [5:0] misses;
   logic [1:0] lives_left;
   logic       hit;
   logic       out_of_lives;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      string tag;
      int    pts;
      int    mis;
      int    liv;
      int    ool;
      int    hit;
   } exp_t;

   exp_t sb[$];

   hit_tracker #(.SCORE_W(6), .NUM_LIGHTS(9)) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .clear_n      (clear_n),
      .enable       (enable),
      .use_lives    (use_lives),
      .lives_init   (lives_init),
      .light_new    (light_new),
      .light_pos    (light_pos),
      .valid_key    (valid_key),
      .key          (key),
      .total_points (total_points),
      .misses       (misses),
      .lives_left   (lives_left),
      .hit          (hit),
      .out_of_lives (out_of_lives)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic ln, input logic [3:0] lp, input logic vk,
                       input logic [3:0] k, input string tag,
                       input int ep, input int em, input int el,
                       input int eo, input int eh);
      exp_t e;
      light_new = ln;
      light_pos = lp;
      valid_key = vk;
      key       = k;
      sb.push_back('{tag: tag, pts: ep, mis: em, liv: el, ool: eo, hit: eh});
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      e = sb.pop_front();
      chk({e.tag, ".pts"}, int'(total_points), e.pts);
      chk({e.tag, ".mis"}, int'(misses), e.mis);
      chk({e.tag, ".liv"}, int'(lives_left), e.liv);
      chk({e.tag, ".ool"}, int'(out_of_lives), e.ool);
      chk({e.tag, ".hit"}, int'(hit), e.hit);
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] lp;
      reset      = 1'b0;
      clear_n    = 1'b1;
      enable     = 1'b0;
      use_lives  = 1'b0;
      lives_init = 2'd3;
      light_new  = 1'b0;
      light_pos  = 4'd0;
      valid_key  = 1'b1;
      key        = 4'd4;
      repeat (3) @(negedge CLOCK_50);
      chk("rst.pts", int'(total_points), 0);
      chk("rst.mis", int'(misses), 0);
      chk("rst.liv", int'(lives_left), 3);
      chk("rst.hit", int'(hit), 0);
      chk("rst.ool", int'(out_of_lives), 0);

      // Key held through reset release must not count until re-pressed.
      reset  = 1'b1;
      enable = 1'b1;
      step(1, 4, 1, 4, "held_arm", 0, 0, 3, 0, 0);
      step(0, 4, 1, 4, "held_stay", 0, 0, 3, 0, 0);
      step(0, 4, 0, 4, "held_rel", 0, 0, 3, 0, 0);

      // One press held ten cycles gives one point and one hit pulse.
      step(0, 4, 1, 4, "hold_edge", 1, 0, 3, 0, 1);
      for (int i = 0; i < 9; i++)
         step(0, 4, 1, 4, "hold_keep", 1, 0, 3, 0, 0);
      step(0, 4, 0, 4, "hold_rel", 1, 0, 3, 0, 0);

      // Unhit light replaced by another: one miss, still armed.
      step(1, 2, 0, 0, "unhit_arm", 1, 0, 3, 0, 0);
      step(0, 2, 0, 0, "unhit_wait", 1, 0, 3, 0, 0);
      step(1, 3, 0, 0, "unhit_new", 1, 1, 3, 0, 0);
      step(0, 3, 1, 3, "unhit_hit", 2, 1, 3, 0, 1);
      step(0, 3, 0, 3, "unhit_rel", 2, 1, 3, 0, 0);

      // Press and new light together, judged against the incoming position.
      step(1, 5, 0, 0, "same_arm", 2, 1, 3, 0, 0);
      step(0, 5, 0, 0, "same_wait", 2, 1, 3, 0, 0);
      step(1, 7, 1, 7, "same_cyc", 3, 2, 3, 0, 1);
      step(0, 7, 0, 7, "same_rel", 3, 2, 3, 0, 0);

      // Key outside the valid range is a wrong press even if it equals light_pos.
      step(1, 9, 0, 0, "range_arm", 3, 2, 3, 0, 0);
      step(0, 9, 1, 9, "range_key", 3, 3, 3, 0, 0);
      step(0, 9, 0, 9, "range_rel", 3, 3, 3, 0, 0);

      // Disabled: events ignored, state drops to idle.
      enable = 1'b0;
      step(1, 0, 1, 0, "dis_evt", 3, 3, 3, 0, 0);
      step(0, 0, 0, 0, "dis_rel", 3, 3, 3, 0, 0);
      enable = 1'b1;
      step(0, 9, 1, 9, "idle_press", 3, 3, 3, 0, 0);
      step(0, 9, 0, 9, "idle_rel", 3, 3, 3, 0, 0);

      // Climb to 63 points, then one more hit saturates but still pulses.
      for (int i = 0; i < 60; i++) begin
         lp = 4'(i % 9);
         step(1, lp, 0, 0, "sat_arm", 3 + i, 3, 3, 0, 0);
         step(0, lp, 1, lp, "sat_hit", 4 + i, 3, 3, 0, 1);
         step(0, lp, 0, lp, "sat_rel", 4 + i, 3, 3, 0, 0);
      end
      step(1, 2, 0, 0, "top_arm", 63, 3, 3, 0, 0);
      step(0, 2, 1, 2, "top_hit", 63, 3, 3, 0, 1);
      step(0, 2, 0, 2, "top_rel", 63, 3, 3, 0, 0);

      // Clear beats a simultaneous correct press.
      step(1, 6, 0, 0, "clr_arm", 63, 3, 3, 0, 0);
      use_lives  = 1'b1;
      lives_init = 2'd2;
      clear_n    = 1'b0;
      step(0, 6, 1, 6, "clr_press", 0, 0, 2, 0, 0);
      clear_n = 1'b1;
      step(0, 6, 0, 6, "clr_rel", 0, 0, 2, 0, 0);

      // Lives mode: two wrong presses exhaust two lives and lock the game.
      step(1, 5, 0, 0, "lives_arm", 0, 0, 2, 0, 0);
      step(0, 5, 1, 1, "lives_w1", 0, 1, 1, 0, 0);
      step(0, 5, 0, 1, "lives_r1", 0, 1, 1, 0, 0);
      step(0, 5, 1, 1, "lives_w2", 0, 2, 0, 1, 0);
      step(0, 5, 0, 1, "lives_r2", 0, 2, 0, 1, 0);
      step(0, 5, 1, 5, "lock_press", 0, 2, 0, 1, 0);
      step(1, 3, 0, 5, "lock_light", 0, 2, 0, 1, 0);
      step(0, 3, 0, 5, "lock_idle", 0, 2, 0, 1, 0);

      // Zero starting lives: no lockout until the first loss.
      lives_init = 2'd0;
      clear_n    = 1'b0;
      step(0, 0, 0, 0, "zero_clr", 0, 0, 0, 0, 0);
      clear_n = 1'b1;
      step(1, 2, 0, 0, "zero_arm", 0, 0, 0, 0, 0);
      step(0, 2, 0, 0, "zero_wait", 0, 0, 0, 0, 0);
      step(1, 4, 0, 0, "zero_loss", 0, 1, 0, 1, 0);

      if (sb.size() != 0)
         chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
